// File: rtl/dual_issue_hazard_ctrl.sv
// Hazard and forwarding controller for the two-lane (A/B) in-order pipeline.
// Tracks in-flight destinations per lane in E and M, produces the registered
// E-stage forward selects, and sequences stall/flush for load-use, cross-lane
// RAW, multi-cycle lane-A MUL and taken branches.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  RUN      | normal issue; hazards and branches evaluated every cycle
//  MUL_BUSY | lane-A MUL still executing in E; F/D/E held, bubble into M
//
// W-stage producers are not tracked: the register file is write-through, so
// a producer in W is already visible to a consumer in D.
module dual_issue_hazard_ctrl #(
  parameter int MUL_LAT    = 3,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] Rs1A_D,
  input  logic [REG_ADDR_W-1:0] Rs2A_D,
  input  logic [REG_ADDR_W-1:0] RdA_D,
  input  logic                  RegWriteA_D,
  input  logic                  LoadA_D,
  input  logic                  MulA_D,
  input  logic [REG_ADDR_W-1:0] Rs1B_D,
  input  logic [REG_ADDR_W-1:0] Rs2B_D,
  input  logic [REG_ADDR_W-1:0] RdB_D,
  input  logic                  RegWriteB_D,
  input  logic                  LoadB_D,
  input  logic                  BranchTaken_E,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushM,
  output logic [1:0]            ForwardA1_E,
  output logic [1:0]            ForwardA2_E,
  output logic [1:0]            ForwardB1_E,
  output logic [1:0]            ForwardB2_E
);

  typedef enum logic {RUN = 1'b0, MUL_BUSY = 1'b1} state_t;

  // The entry cycle is itself one stall cycle, so MUL_BUSY lasts MUL_LAT-2
  // cycles; with MUL_LAT==2 the entry cycle alone covers the whole stall.
  localparam int              CNT_W      = (MUL_LAT > 3) ? $clog2(MUL_LAT - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'((MUL_LAT >= 2) ? (MUL_LAT - 2) : 0);
  localparam state_t          ENTRY_NEXT = (MUL_LAT > 2) ? MUL_BUSY : RUN;
  localparam logic            ENTRY_SERVED = (MUL_LAT == 2);

  localparam logic [1:0] SEL_RF = 2'b00;
  localparam logic [1:0] SEL_W  = 2'b01;
  localparam logic [1:0] SEL_M  = 2'b10;

  // tracking registers
  logic [REG_ADDR_W-1:0] r_rd_a_e, r_rd_a_m, r_rd_b_e, r_rd_b_m;
  logic                  r_rw_a_e, r_rw_a_m, r_rw_b_e, r_rw_b_m;
  logic                  r_ld_a_e, r_ld_b_e, r_mul_a_e;
  logic [1:0]            r_fa1, r_fa2, r_fb1, r_fb2;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_served;

  function automatic logic hit(input logic [REG_ADDR_W-1:0] rs,
                               input logic [REG_ADDR_W-1:0] rd,
                               input logic                  we);
    return we && (rd != '0) && (rs == rd);
  endfunction

  // same-lane matches against E and M
  logic w_a1_ae, w_a2_ae, w_a1_am, w_a2_am;
  logic w_b1_be, w_b2_be, w_b1_bm, w_b2_bm;
  logic w_load_use, w_cross, w_mul_start, w_mul_stall, w_branch, w_hz;
  logic [1:0] w_fa1, w_fa2, w_fb1, w_fb2;

  assign w_a1_ae = hit(Rs1A_D, r_rd_a_e, r_rw_a_e);
  assign w_a2_ae = hit(Rs2A_D, r_rd_a_e, r_rw_a_e);
  assign w_a1_am = hit(Rs1A_D, r_rd_a_m, r_rw_a_m);
  assign w_a2_am = hit(Rs2A_D, r_rd_a_m, r_rw_a_m);
  assign w_b1_be = hit(Rs1B_D, r_rd_b_e, r_rw_b_e);
  assign w_b2_be = hit(Rs2B_D, r_rd_b_e, r_rw_b_e);
  assign w_b1_bm = hit(Rs1B_D, r_rd_b_m, r_rw_b_m);
  assign w_b2_bm = hit(Rs2B_D, r_rd_b_m, r_rw_b_m);

  assign w_load_use = ((w_a1_ae || w_a2_ae) && r_ld_a_e) ||
                      ((w_b1_be || w_b2_be) && r_ld_b_e);

  // no forwarding path between lanes: any other-lane producer in E or M waits
  assign w_cross = hit(Rs1A_D, r_rd_b_e, r_rw_b_e) || hit(Rs2A_D, r_rd_b_e, r_rw_b_e) ||
                   hit(Rs1A_D, r_rd_b_m, r_rw_b_m) || hit(Rs2A_D, r_rd_b_m, r_rw_b_m) ||
                   hit(Rs1B_D, r_rd_a_e, r_rw_a_e) || hit(Rs2B_D, r_rd_a_e, r_rw_a_e) ||
                   hit(Rs1B_D, r_rd_a_m, r_rw_a_m) || hit(Rs2B_D, r_rd_a_m, r_rw_a_m);

  assign w_mul_start = (MUL_LAT > 1) && (r_state == RUN) && r_mul_a_e && !r_served;
  assign w_mul_stall = w_mul_start || (r_state == MUL_BUSY);
  assign w_branch    = !w_mul_stall && BranchTaken_E;
  assign w_hz        = !w_mul_stall && !BranchTaken_E && (w_load_use || w_cross);

  assign StallF = w_mul_stall || w_hz;
  assign StallD = w_mul_stall || w_hz;
  assign StallE = w_mul_stall;
  assign FlushM = w_mul_stall;
  assign FlushD = w_branch;
  assign FlushE = w_branch || w_hz;

  // E producer wins over M; a load in E cannot forward (load-use stalls instead)
  assign w_fa1 = (w_a1_ae && !r_ld_a_e) ? SEL_M : (w_a1_am ? SEL_W : SEL_RF);
  assign w_fa2 = (w_a2_ae && !r_ld_a_e) ? SEL_M : (w_a2_am ? SEL_W : SEL_RF);
  assign w_fb1 = (w_b1_be && !r_ld_b_e) ? SEL_M : (w_b1_bm ? SEL_W : SEL_RF);
  assign w_fb2 = (w_b2_be && !r_ld_b_e) ? SEL_M : (w_b2_bm ? SEL_W : SEL_RF);

  assign ForwardA1_E = r_fa1;
  assign ForwardA2_E = r_fa2;
  assign ForwardB1_E = r_fb1;
  assign ForwardB2_E = r_fb2;

  // MUL sequencing: entry stall, MUL_BUSY countdown, served flag until E moves
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= RUN;
      r_cnt    <= '0;
      r_served <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_mul_start) begin
            r_state  <= ENTRY_NEXT;
            r_cnt    <= CNT_LOAD;
            r_served <= ENTRY_SERVED;
          end else begin
            r_served <= 1'b0;
          end
        end
        MUL_BUSY: begin
          if (r_cnt <= CNT_W'(1)) begin
            r_state  <= RUN;
            r_cnt    <= '0;
            r_served <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  // D->E->M shift of tracking state and E-stage forward selects
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_a_e  <= '0;  r_rw_a_e <= 1'b0; r_ld_a_e <= 1'b0; r_mul_a_e <= 1'b0;
      r_rd_b_e  <= '0;  r_rw_b_e <= 1'b0; r_ld_b_e <= 1'b0;
      r_rd_a_m  <= '0;  r_rw_a_m <= 1'b0;
      r_rd_b_m  <= '0;  r_rw_b_m <= 1'b0;
      r_fa1 <= SEL_RF; r_fa2 <= SEL_RF; r_fb1 <= SEL_RF; r_fb2 <= SEL_RF;
    end else begin
      if (!StallE) begin
        if (FlushE) begin
          r_rw_a_e <= 1'b0; r_ld_a_e <= 1'b0; r_mul_a_e <= 1'b0;
          r_rw_b_e <= 1'b0; r_ld_b_e <= 1'b0;
          r_fa1 <= SEL_RF; r_fa2 <= SEL_RF; r_fb1 <= SEL_RF; r_fb2 <= SEL_RF;
        end else begin
          r_rd_a_e <= RdA_D; r_rw_a_e <= RegWriteA_D; r_ld_a_e <= LoadA_D;
          r_mul_a_e <= MulA_D;
          r_rd_b_e <= RdB_D; r_rw_b_e <= RegWriteB_D; r_ld_b_e <= LoadB_D;
          r_fa1 <= w_fa1; r_fa2 <= w_fa2; r_fb1 <= w_fb1; r_fb2 <= w_fb2;
        end
      end
      if (FlushM) begin
        r_rw_a_m <= 1'b0;
        r_rw_b_m <= 1'b0;
      end else begin
        r_rd_a_m <= r_rd_a_e; r_rw_a_m <= r_rw_a_e;
        r_rd_b_m <= r_rd_b_e; r_rw_b_m <= r_rw_b_e;
      end
    end
  end

endmodule

// File: tb/tb_dual_issue_hazard_ctrl.sv
// Directed bench for dual_issue_hazard_ctrl with MUL_LAT=3.
// ctl = {StallF,StallD,StallE,FlushD,FlushE,FlushM}
// sel = {ForwardA1_E,ForwardA2_E,ForwardB1_E,ForwardB2_E}
module tb_dual_issue_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1A_D, Rs2A_D, RdA_D, Rs1B_D, Rs2B_D, RdB_D;
  logic       RegWriteA_D, LoadA_D, MulA_D, RegWriteB_D, LoadB_D, BranchTaken_E;
  logic       StallF, StallD, StallE, FlushD, FlushE, FlushM;
  logic [1:0] ForwardA1_E, ForwardA2_E, ForwardB1_E, ForwardB2_E;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_HZ   = 6'b110010;
  localparam logic [5:0] C_MUL  = 6'b111001;
  localparam logic [5:0] C_BR   = 6'b000110;

  logic [5:0] ctl;
  logic [7:0] sel;
  assign ctl = {StallF, StallD, StallE, FlushD, FlushE, FlushM};
  assign sel = {ForwardA1_E, ForwardA2_E, ForwardB1_E, ForwardB2_E};

  always #5 clk = ~clk;

  dual_issue_hazard_ctrl #(.MUL_LAT(3), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .Rs1A_D(Rs1A_D), .Rs2A_D(Rs2A_D), .RdA_D(RdA_D),
    .RegWriteA_D(RegWriteA_D), .LoadA_D(LoadA_D), .MulA_D(MulA_D),
    .Rs1B_D(Rs1B_D), .Rs2B_D(Rs2B_D), .RdB_D(RdB_D),
    .RegWriteB_D(RegWriteB_D), .LoadB_D(LoadB_D),
    .BranchTaken_E(BranchTaken_E),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .ForwardA1_E(ForwardA1_E), .ForwardA2_E(ForwardA2_E),
    .ForwardB1_E(ForwardB1_E), .ForwardB2_E(ForwardB2_E)
  );

  task automatic drive(input logic [4:0] a1, a2, ad, input logic aw, al, am,
                       input logic [4:0] b1, b2, bd, input logic bw, bl);
    Rs1A_D = a1; Rs2A_D = a2; RdA_D = ad; RegWriteA_D = aw; LoadA_D = al; MulA_D = am;
    Rs1B_D = b1; Rs2B_D = b2; RdB_D = bd; RegWriteB_D = bw; LoadB_D = bl;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // advance one cycle; inputs are then driven at posedge+1, checks at posedge+2
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    BranchTaken_E = 1'b0;
    nop();
    tick(); tick(); tick();
    #1;
    if (ctl !== C_NONE || sel !== 8'h00) begin $display("FAIL drain: ctl=%b sel=%h want ctl=%b sel=00", ctl, sel, C_NONE); miscompares++; end vectors++;
  endtask

  task automatic test_reset();
    reset = 1'b1; BranchTaken_E = 1'b0; nop();
    tick(); tick();
    #1;
    if (ctl !== C_NONE || sel !== 8'h00) begin $display("FAIL reset_state: ctl=%b sel=%h want 000000/00", ctl, sel); miscompares++; end vectors++;
    reset = 1'b0;
  endtask

  task automatic test_same_lane_fwd();
    tick(); drive(1, 2, 5, 1, 0, 0, 0, 0, 0, 0, 0); #1;
    if (ctl !== C_NONE) begin $display("FAIL fwd_issue: ctl=%b want %b", ctl, C_NONE); miscompares++; end vectors++;
    tick(); drive(3, 5, 8, 1, 0, 0, 0, 0, 0, 0, 0); #1;
    if (ctl !== C_NONE) begin $display("FAIL fwd_e_nostall: ctl=%b want %b", ctl, C_NONE); miscompares++; end vectors++;
    tick(); drive(5, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0); #1;
    if (sel !== 8'h20) begin $display("FAIL fwd_a2_m: sel=%h want 20", sel); miscompares++; end vectors++;
    if (ctl !== C_NONE) begin $display("FAIL fwd_m_nostall: ctl=%b want %b", ctl, C_NONE); miscompares++; end vectors++;
    tick(); nop(); #1;
    if (sel !== 8'h40) begin $display("FAIL fwd_a1_w: sel=%h want 40", sel); miscompares++; end vectors++;
    drain();
  endtask

  task automatic test_dual_lane_fwd();
    tick(); drive(0, 0, 3, 1, 0, 0, 0, 0, 4, 1, 0); #1;
    tick(); drive(3, 3, 10, 1, 0, 0, 0, 4, 11, 1, 0); #1;
    if (ctl !== C_NONE) begin $display("FAIL dual_nostall: ctl=%b want %b", ctl, C_NONE); miscompares++; end vectors++;
    tick(); nop(); #1;
    if (sel !== 8'hA2) begin $display("FAIL dual_sel: sel=%h want a2", sel); miscompares++; end vectors++;
    drain();
  endtask

  task automatic test_x0();
    tick(); drive(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0); #1;
    tick(); drive(0, 0, 12, 1, 0, 0, 0, 0, 13, 1, 0); #1;
    if (ctl !== C_NONE) begin $display("FAIL x0_nostall: ctl=%b want %b", ctl, C_NONE); miscompares++; end vectors++;
    tick(); nop(); #1;
    if (sel !== 8'h00) begin $display("FAIL x0_sel: sel=%h want 00", sel); miscompares++; end vectors++;
    drain();
  endtask

  task automatic test_load_use();
    tick(); drive(1, 0, 6, 1, 1, 0, 0, 0, 0, 0, 0); #1;
    tick(); drive(6, 0, 10, 1, 0, 0, 0, 0, 0, 0, 0); #1;
    if (ctl !== C_HZ) begin $display("FAIL lu_stall: ctl=%b want %b", ctl, C_HZ); miscompares++; end vectors++;
    tick(); #1;
    if (ctl !== C_NONE) begin $display("FAIL lu_release: ctl=%b want %b", ctl, C_NONE); miscompares++; end vectors++;
    if (sel !== 8'h00) begin $display("FAIL lu_bubble_sel: sel=%h want 00", sel); miscompares++; end vectors++;
    tick(); nop(); #1;
    if (sel !== 8'h40) begin $display("FAIL lu_fwd_w: sel=%h want 40", sel); miscompares++; end vectors++;
    drain();
  endtask

  task automatic test_cross_lane();
    tick(); drive(0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0); #1;
    tick(); drive(0, 0, 0, 0, 0, 0, 7, 0, 11, 1, 0); #1;
    if (ctl !== C_HZ) begin $display("FAIL xl_e_stall1: ctl=%b want %b", ctl, C_HZ); miscompares++; end vectors++;
    tick(); #1;
    if (ctl !== C_HZ) begin $display("FAIL xl_e_stall2: ctl=%b want %b", ctl, C_HZ); miscompares++; end vectors++;
    tick(); #1;
    if (ctl !== C_NONE) begin $display("FAIL xl_e_release: ctl=%b want %b", ctl, C_NONE); miscompares++; end vectors++;
    tick(); nop(); #1;
    if (sel !== 8'h00) begin $display("FAIL xl_sel: sel=%h want 00", sel); miscompares++; end vectors++;
    drain();
    tick(); drive(0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0); #1;
    tick(); drive(0, 0, 12, 1, 0, 0, 0, 0, 0, 0, 0); #1;
    if (ctl !== C_NONE) begin $display("FAIL xl_filler: ctl=%b want %b", ctl, C_NONE); miscompares++; end vectors++;
    tick(); drive(0, 0, 0, 0, 0, 0, 7, 0, 11, 1, 0); #1;
    if (ctl !== C_HZ) begin $display("FAIL xl_m_stall: ctl=%b want %b", ctl, C_HZ); miscompares++; end vectors++;
    tick(); #1;
    if (ctl !== C_NONE) begin $display("FAIL xl_m_release: ctl=%b want %b", ctl, C_NONE); miscompares++; end vectors++;
    drain();
  endtask

  task automatic test_mul();
    tick(); drive(1, 2, 13, 1, 0, 1, 0, 0, 0, 0, 0); #1;
    tick(); drive(13, 0, 14, 1, 0, 0, 0, 0, 0, 0, 0); #1;
    if (ctl !== C_MUL) begin $display("FAIL mul_stall1: ctl=%b want %b", ctl, C_MUL); miscompares++; end vectors++;
    tick(); #1;
    if (ctl !== C_MUL) begin $display("FAIL mul_stall2: ctl=%b want %b", ctl, C_MUL); miscompares++; end vectors++;
    tick(); #1;
    if (ctl !== C_NONE) begin $display("FAIL mul_exit: ctl=%b want %b", ctl, C_NONE); miscompares++; end vectors++;
    tick(); nop(); #1;
    if (sel !== 8'h80) begin $display("FAIL mul_dep_sel: sel=%h want 80", sel); miscompares++; end vectors++;
    if (ctl !== C_NONE) begin $display("FAIL mul_after: ctl=%b want %b", ctl, C_NONE); miscompares++; end vectors++;
    drain();
  endtask

  task automatic test_branch();
    tick(); drive(1, 0, 6, 1, 1, 0, 0, 0, 0, 0, 0); #1;
    tick(); drive(6, 0, 10, 1, 0, 0, 0, 0, 0, 0, 0); BranchTaken_E = 1'b1; #1;
    if (ctl !== C_BR) begin $display("FAIL br_over_lu: ctl=%b want %b", ctl, C_BR); miscompares++; end vectors++;
    tick(); nop(); BranchTaken_E = 1'b0; #1;
    if (ctl !== C_NONE || sel !== 8'h00) begin $display("FAIL br_after: ctl=%b sel=%h want 000000/00", ctl, sel); miscompares++; end vectors++;
    drain();
    tick(); drive(1, 2, 13, 1, 0, 1, 0, 0, 0, 0, 0); #1;
    tick(); nop(); BranchTaken_E = 1'b1; #1;
    if (ctl !== C_MUL) begin $display("FAIL br_mul_entry: ctl=%b want %b", ctl, C_MUL); miscompares++; end vectors++;
    tick(); #1;
    if (ctl !== C_MUL) begin $display("FAIL br_mul_busy: ctl=%b want %b", ctl, C_MUL); miscompares++; end vectors++;
    tick(); #1;
    if (ctl !== C_BR) begin $display("FAIL br_mul_exit: ctl=%b want %b", ctl, C_BR); miscompares++; end vectors++;
    tick(); BranchTaken_E = 1'b0; #1;
    if (ctl !== C_NONE) begin $display("FAIL br_mul_after: ctl=%b want %b", ctl, C_NONE); miscompares++; end vectors++;
    drain();
  endtask

  task automatic test_reset_mid_mul();
    tick(); drive(1, 2, 13, 1, 0, 1, 0, 0, 0, 0, 0); #1;
    tick(); nop(); #1;
    tick(); reset = 1'b1; #1;
    if (ctl !== C_MUL) begin $display("FAIL rst_busy: ctl=%b want %b", ctl, C_MUL); miscompares++; end vectors++;
    tick(); reset = 1'b0; drive(13, 0, 15, 1, 0, 0, 13, 0, 16, 1, 0); #1;
    if (ctl !== C_NONE || sel !== 8'h00) begin $display("FAIL rst_clear: ctl=%b sel=%h want 000000/00", ctl, sel); miscompares++; end vectors++;
    tick(); nop(); #1;
    if (sel !== 8'h00) begin $display("FAIL rst_tracking: sel=%h want 00", sel); miscompares++; end vectors++;
    drain();
  endtask

  initial begin
    test_reset();
    test_same_lane_fwd();
    test_dual_lane_fwd();
    test_x0();
    test_load_use();
    test_cross_lane();
    test_mul();
    test_branch();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
